// File: rtl/scope_trig_capture_pkg.sv
// Shared types and constants for the trigger-based sample capture engine.
package scope_trig_capture_pkg;

    // Capture FSM states; encodings are exported on state_o for the status display.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_HOLD = 3'd4
    } scope_state_e;

    // Acquisition mode codes; code 2'b11 behaves like normal mode.
    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_NORM   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    // True when the mode re-arms by itself from IDLE (everything except single-shot).
    function automatic logic autoRearm(input logic [1:0] modeVal);
        return modeVal != MODE_SINGLE;
    endfunction

endpackage

// File: rtl/scope_trig_capture_if.sv
// Write port towards the dual-port sample RAM.
interface scope_trig_capture_if #(
    parameter int AW  = 10,
    parameter int DW  = 12,
    parameter int NCH = 2
);

    logic                ram_wr_en;
    logic [AW-1:0]       ram_wr_addr;
    logic [NCH*DW-1:0]   ram_wr_data;

    // The capture engine drives the port, the RAM consumes it.
    modport master (output ram_wr_en, ram_wr_addr, ram_wr_data);
    modport slave  (input  ram_wr_en, ram_wr_addr, ram_wr_data);

endinterface

// File: rtl/scope_trig_capture_det.sv
// Trigger detector: selects the trigger channel, remembers the previous
// qualified sample and flags a level crossing in the selected direction.
module scope_trig_det
    import scope_trig_capture_pkg::*;
#(
    parameter int DW  = 12,
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              q_i,
    input  logic              eval_i,
    input  logic [NCH*DW-1:0] smp_i,
    input  logic [CHW-1:0]    ch_i,
    input  logic [DW-1:0]     level_i,
    input  logic              slope_i,
    output logic              hit_o
);

    logic [DW-1:0] cur;
    logic [DW-1:0] prev_q;
    logic          prevVld_q;
    logic          crossing;

    // Channel mux; an out-of-range channel number reads as zero.
    always_comb begin
        cur = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_i == CHW'(k)) begin
                cur = smp_i[k*DW +: DW];
            end
        end
    end

    // Remember the last qualified sample; forgotten at the start of every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prevVld_q <= 1'b0;
        end else if (clr_i) begin
            prevVld_q <= 1'b0;
        end else if (q_i) begin
            prev_q    <= cur;
            prevVld_q <= 1'b1;
        end
    end

    // Unsigned level/slope compare against the previous sample.
    always_comb begin
        if (slope_i) begin
            crossing = (prev_q > level_i) && (cur <= level_i);
        end else begin
            crossing = (prev_q < level_i) && (cur >= level_i);
        end
    end

    assign hit_o = eval_i && prevVld_q && crossing;

endmodule

// File: rtl/scope_trig_capture.sv
// Trigger-based multi-channel capture engine: writes samples circularly into
// the sample RAM, waits for a level/slope trigger (or an auto timeout) and
// freezes one frame with a configurable number of pre-trigger samples.
module scope_trig_capture
    import scope_trig_capture_pkg::*;
#(
    parameter int DW    = 12,
    parameter int AW    = 10,
    parameter int NCH   = 2,
    parameter int DEC_W = 8,
    parameter int TO_W  = 16,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] smp_in,
    input  logic              smp_vld,
    input  logic [CHW-1:0]    trig_ch,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic [AW-1:0]     pretrig,
    input  logic [DEC_W-1:0]  decim,
    input  logic [TO_W-1:0]   auto_tmo,
    input  logic              rd_done,
    scope_trig_capture_if.master ramIf,
    output logic              frame_rdy,
    output logic [AW-1:0]     frame_base,
    output logic              trig_real,
    output logic [2:0]        state_o
);

    scope_state_e      state_q;

    logic [CHW-1:0]    cfgCh_q;
    logic [DW-1:0]     cfgLevel_q;
    logic              cfgSlope_q;
    logic [1:0]        cfgMode_q;
    logic [AW-1:0]     cfgPre_q;
    logic [DEC_W-1:0]  cfgDecim_q;
    logic [TO_W-1:0]   cfgTmo_q;

    logic [DEC_W-1:0]  dcnt_q, dcnt_d;
    logic [AW-1:0]     wp_q;
    logic [AW-1:0]     preCnt_q;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [AW-1:0]     postCnt_q;
    logic [AW-1:0]     trigAddr_q;
    logic              trigPend_q;

    logic              wrEn_q;
    logic [AW-1:0]     wrAddr_q;
    logic [NCH*DW-1:0] wrData_q;
    logic              frameRdy_q;
    logic [AW-1:0]     frameBase_q;
    logic              trigReal_q;

    logic              goPre;
    logic              sampleWin;
    logic              q;
    logic              hit;
    logic              timeout;

    // Leaving IDLE: free-running modes re-arm at once, single-shot needs arm.
    assign goPre = (state_q == ST_IDLE) && (autoRearm(mode) || arm);

    // Samples are only accepted while a frame is being filled. A zero pretrig
    // lets PRE pass straight through, and a POST with no samples left is
    // just the hand-over cycle into HOLD; neither accepts a sample.
    assign sampleWin = ((state_q == ST_PRE) && (cfgPre_q != '0)) ||
                       (state_q == ST_WAIT) ||
                       ((state_q == ST_POST) && (postCnt_q != '0));

    assign q = sampleWin && smp_vld && (dcnt_q == '0);

    assign tcnt_d  = tcnt_q + 1'b1;
    assign timeout = (cfgMode_q == MODE_AUTO) && (cfgTmo_q != '0) && (tcnt_d == cfgTmo_q);

    scope_trig_det #(
        .DW  (DW),
        .NCH (NCH),
        .CHW (CHW)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (goPre),
        .q_i     (q && ((state_q == ST_PRE) || (state_q == ST_WAIT))),
        .eval_i  (q && (state_q == ST_WAIT)),
        .smp_i   (smp_in),
        .ch_i    (cfgCh_q),
        .level_i (cfgLevel_q),
        .slope_i (cfgSlope_q),
        .hit_o   (hit)
    );

    // Decimator next value: keep one of every decim+1 valid samples.
    always_comb begin
        dcnt_d = dcnt_q;
        if (sampleWin && smp_vld) begin
            if (dcnt_q == '0) begin
                dcnt_d = cfgDecim_q;
            end else begin
                dcnt_d = dcnt_q - 1'b1;
            end
        end
    end

    // Decimator counter; cleared at frame start so the first valid sample is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
        end else if (goPre) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    // Capture FSM with config latch, pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfgCh_q     <= '0;
            cfgLevel_q  <= '0;
            cfgSlope_q  <= 1'b0;
            cfgMode_q   <= MODE_AUTO;
            cfgPre_q    <= '0;
            cfgDecim_q  <= '0;
            cfgTmo_q    <= '0;
            wp_q        <= '0;
            preCnt_q    <= '0;
            tcnt_q      <= '0;
            postCnt_q   <= '0;
            trigAddr_q  <= '0;
            trigPend_q  <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            frameRdy_q  <= 1'b0;
            frameBase_q <= '0;
            trigReal_q  <= 1'b0;
        end else begin
            wrEn_q <= q;
            if (q) begin
                wrAddr_q <= wp_q;
                wrData_q <= smp_in;
                wp_q     <= wp_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (goPre) begin
                        // pretrig is AW bits wide, so it can never exceed DEPTH-1.
                        cfgCh_q    <= trig_ch;
                        cfgLevel_q <= trig_level;
                        cfgSlope_q <= trig_slope;
                        cfgMode_q  <= mode;
                        cfgPre_q   <= pretrig;
                        cfgDecim_q <= decim;
                        cfgTmo_q   <= auto_tmo;
                        preCnt_q   <= '0;
                        tcnt_q     <= '0;
                        state_q    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (cfgPre_q == '0) begin
                        state_q <= ST_WAIT;
                    end else if (q) begin
                        preCnt_q <= preCnt_q + 1'b1;
                        if (preCnt_q + 1'b1 == cfgPre_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (q) begin
                        tcnt_q <= tcnt_d;
                        if (hit || timeout) begin
                            trigAddr_q <= wp_q;
                            trigPend_q <= hit;
                            postCnt_q  <= {AW{1'b1}} - cfgPre_q;
                            state_q    <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (postCnt_q == '0) begin
                        frameRdy_q  <= 1'b1;
                        frameBase_q <= trigAddr_q - cfgPre_q;
                        trigReal_q  <= trigPend_q;
                        state_q     <= ST_HOLD;
                    end else if (q) begin
                        postCnt_q <= postCnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rd_done) begin
                        frameRdy_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    frameRdy_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ramIf.ram_wr_en   = wrEn_q;
    assign ramIf.ram_wr_addr = wrAddr_q;
    assign ramIf.ram_wr_data = wrData_q;
    assign frame_rdy         = frameRdy_q;
    assign frame_base        = frameBase_q;
    assign trig_real         = trigReal_q;
    assign state_o           = state_q;

endmodule
